// File: rtl/rc5_decrypt_core.sv
// rc5_decrypt_core: iterative RC5-W/R block decryptor, one round per clock.
// Optional key lock while busy: define RC5_DEC_KEY_LOCK_EN.
module rc5_decrypt_core #(
   parameter int W = 16,
   parameter int R = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         key_we_i,
   input  logic [$clog2(2*R+2)-1:0]     key_addr_i,
   input  logic [W-1:0]                 key_data_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [W-1:0]                 ct_a_i,
   input  logic [W-1:0]                 ct_b_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [W-1:0]                 pt_a_o,
   output logic [W-1:0]                 pt_b_o,
   output logic                         busy_o,
   output logic                         key_err_o
);

   localparam int T  = 2 * R + 2;
   localparam int AW = $clog2(T);
   localparam int LG = $clog2(W);

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      FINAL,
      DONE
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [W-1:0]  s_tab [2**AW];
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [AW-1:0] i_q;
   logic          out_valid_q;
   logic [AW-1:0] ib;
   logic [AW-1:0] ia;
   logic [W-1:0]  b_rnd;
   logic [W-1:0]  a_rnd;
   logic          key_lock;
   logic          key_ok;

   function automatic logic [W-1:0] rotr(
      input logic [W-1:0]  x,
      input logic [LG-1:0] n
   );
      logic [2*W-1:0] t;
      t = {x, x} >> n;
      return t[W-1:0];
   endfunction

   // Round i reads S[2i] for B and S[2i-1] for A.
   always_comb begin
      ib    = i_q << 1;
      ia    = ib - AW'(1);
      b_rnd = rotr(b_q - s_tab[ib], a_q[LG-1:0]) ^ a_q;
      a_rnd = rotr(a_q - s_tab[ia], b_rnd[LG-1:0]) ^ b_rnd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid_i) state_d = ROUND;
         ROUND:   if (i_q == AW'(1)) state_d = FINAL;
         FINAL:   state_d = DONE;
         DONE:    if (out_valid_q && out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         i_q         <= AW'(R);
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_q <= ct_a_i;
                  b_q <= ct_b_i;
                  i_q <= AW'(R);
               end
            end
            ROUND: begin
               a_q <= a_rnd;
               b_q <= b_rnd;
               i_q <= i_q - AW'(1);
            end
            FINAL: begin
               a_q         <= a_q - s_tab[0];
               b_q         <= b_q - s_tab[1];
               out_valid_q <= 1'b1;
            end
            DONE: begin
               if (out_ready_i) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready_o  = (state_q == IDLE);
      busy_o      = (state_q != IDLE);
      out_valid_o = out_valid_q;
      pt_a_o      = a_q;
      pt_b_o      = b_q;
   end

`ifdef RC5_DEC_KEY_LOCK_EN
   assign key_lock = (state_q != IDLE);
`else
   assign key_lock = 1'b0;
`endif

   assign key_err_o = key_we_i && key_lock;
   assign key_ok    = key_we_i && !key_lock &&
                      ({1'b0, key_addr_i} < (AW+1)'(T));

   // Table is deliberately not reset; reads are combinational (old value on collision).
   always_ff @(posedge clk) begin
      if (key_ok) s_tab[key_addr_i] <= key_data_i;
   end

endmodule

// File: tb/tb_rc5_decrypt_core.sv
// tb_rc5_decrypt_core: directed checks of rc5_decrypt_core at R=1 and R=12.
// R=12 blocks are checked by decrypting ciphertext from a bench-side encryptor.
module tb_rc5_decrypt_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        k1_we, v1, rdy1, ov1, or1, busy1, err1;
   logic [1:0]  k1_addr;
   logic [15:0] k1_data, ca1, cb1, pa1, pb1;

   logic        k12_we, v12, rdy12, ov12, or12, busy12, err12;
   logic [4:0]  k12_addr;
   logic [15:0] k12_data, ca12, cb12, pa12, pb12;

   rc5_decrypt_core #(.W(16), .R(1)) d1 (
      .clk(clk), .rst_n(rst_n),
      .key_we_i(k1_we), .key_addr_i(k1_addr), .key_data_i(k1_data),
      .in_valid_i(v1), .in_ready_o(rdy1),
      .ct_a_i(ca1), .ct_b_i(cb1),
      .out_valid_o(ov1), .out_ready_i(or1),
      .pt_a_o(pa1), .pt_b_o(pb1),
      .busy_o(busy1), .key_err_o(err1)
   );

   rc5_decrypt_core #(.W(16), .R(12)) d12 (
      .clk(clk), .rst_n(rst_n),
      .key_we_i(k12_we), .key_addr_i(k12_addr), .key_data_i(k12_data),
      .in_valid_i(v12), .in_ready_o(rdy12),
      .ct_a_i(ca12), .ct_b_i(cb12),
      .out_valid_o(ov12), .out_ready_i(or12),
      .pt_a_o(pa12), .pt_b_o(pb12),
      .busy_o(busy12), .key_err_o(err12)
   );

   int passed = 0;
   int total  = 0;
   logic [15:0] st [26];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rotl(input logic [15:0] x,
                                        input logic [3:0] n);
      logic [31:0] t;
      t = {x, x} << n;
      return t[31:16];
   endfunction

   // Forward cipher whose exact inverse is the core's decryption schedule.
   function automatic void enc(input logic [15:0] pa, input logic [15:0] pb,
                               output logic [15:0] ca, output logic [15:0] cb);
      logic [15:0] a, b;
      a = pa + st[0];
      b = pb + st[1];
      for (int i = 1; i <= 12; i++) begin
         a = rotl(a ^ b, b[3:0]) + st[2*i-1];
         b = rotl(b ^ a, a[3:0]) + st[2*i];
      end
      ca = a;
      cb = b;
   endfunction

   task automatic key1(input int a, input logic [15:0] d);
      k1_we = 1'b1; k1_addr = 2'(a); k1_data = d;
      tick();
      k1_we = 1'b0;
   endtask

   task automatic key12(input int a, input logic [15:0] d);
      k12_we = 1'b1; k12_addr = 5'(a); k12_data = d;
      tick();
      k12_we = 1'b0;
   endtask

   task automatic blk1(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] pa, output logic [15:0] pb,
                       output int lat);
      ca1 = a; cb1 = b; v1 = 1'b1; or1 = 1'b0;
      tick();
      v1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 50) begin tick(); lat++; end
      pa = pa1; pb = pb1;
      or1 = 1'b1;
      tick();
      or1 = 1'b0;
   endtask

   task automatic blk12(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] pa, output logic [15:0] pb,
                        output int lat, output logic rdy_ok);
      ca12 = a; cb12 = b; v12 = 1'b1; or12 = 1'b0;
      tick();
      v12 = 1'b0;
      lat = 0;
      rdy_ok = 1'b1;
      while (!ov12 && lat < 100) begin
         rdy_ok &= !rdy12;
         tick();
         lat++;
      end
      rdy_ok &= !rdy12;
      pa = pa12; pb = pb12;
      or12 = 1'b1;
      tick();
      or12 = 1'b0;
      rdy_ok &= rdy12;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] pa, pb, qa, qb, ca, cb;
      int          lat;
      logic        ok, lat_ok, rdy_all;

      k1_we = 0; k1_addr = 0; k1_data = 0; v1 = 0; ca1 = 0; cb1 = 0; or1 = 0;
      k12_we = 0; k12_addr = 0; k12_data = 0; v12 = 0; ca12 = 0; cb12 = 0;
      or12 = 0;
      for (int k = 0; k < 26; k++) st[k] = 16'(k * 257);
      #1;
      chk("rst_ready", 32'(rdy1), 32'h1);
      chk("rst_valid", 32'(ov1), 32'h0);
      chk("rst_pt", {pa1, pb1}, 32'h0);
      chk("rst_busy", 32'(busy1), 32'h0);
      chk("rst_err", 32'(err1), 32'h0);
      chk("rst_ready12", 32'(rdy12), 32'h1);
      chk("rst_pt12", {pa12, pb12}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 4; k++) key1(k, 16'h0);
      blk1(16'h0001, 16'h8001, pa, pb, lat);
      chk("v1_pt", {pa, pb}, 32'h4001_C001);
      chk("v1_latency", 32'(lat), 32'd2);
      chk("v1_idle_after", 32'(rdy1), 32'h1);

      blk1(16'h0010, 16'h1234, pa, pb, lat);
      chk("rot0_pt", {pa, pb}, 32'h1225_1224);

      // Backpressure with a competing block held on the input.
      ca1 = 16'h0001; cb1 = 16'h8001; v1 = 1'b1; or1 = 1'b0;
      tick();
      ca1 = 16'hFFFF; cb1 = 16'hFFFF;
      lat = 0;
      while (!ov1 && lat < 50) begin tick(); lat++; end
      pa = pa1; pb = pb1;
      ok = 1'b1;
      repeat (10) begin
         tick();
         ok &= ov1 && (pa1 == pa) && (pb1 == pb) && !rdy1 && busy1;
      end
      chk("bp_hold", 32'(ok), 32'h1);
      chk("bp_pt", {pa, pb}, 32'h4001_C001);
      or1 = 1'b1;
      tick();
      or1 = 1'b0;
      v1 = 1'b0;
      chk("bp_release_state", {29'h0, rdy1, ov1, busy1}, 32'h4);
      chk("bp_not_consumed", {pa1, pb1}, 32'h4001_C001);
      tick();

      key1(0, 16'd1); key1(1, 16'd2); key1(2, 16'd3); key1(3, 16'd4);
      blk1(16'h0001, 16'h8001, pa, pb, lat);
      chk("keyed_pt", {pa, pb}, 32'hC000_3FFC);
      for (int k = 0; k < 4; k++) key1(k, 16'h0);

      for (int k = 0; k < 26; k++) key12(k, st[k]);
      lat_ok = 1'b1;
      rdy_all = 1'b1;
      for (int n = 0; n < 200; n++) begin
         qa = 16'($urandom);
         qb = 16'($urandom);
         enc(qa, qb, ca, cb);
         blk12(ca, cb, pa, pb, lat, ok);
         chk($sformatf("rt%0d", n), {pa, pb}, {qa, qb});
         lat_ok &= (lat == 13);
         rdy_all &= ok;
      end
      chk("rt_latency", 32'(lat_ok), 32'h1);
      chk("rt_ready_low", 32'(rdy_all), 32'h1);

      // Reset in the middle of the fifth round.
      enc(16'hA5A5, 16'h5A5A, ca, cb);
      ca12 = ca; cb12 = cb; v12 = 1'b1;
      tick();
      v12 = 1'b0;
      repeat (4) tick();
      chk("mid_busy", 32'(busy12), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", {29'h0, rdy12, ov12, busy12}, 32'h4);
      chk("mid_rst_pt", {pa12, pb12}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      blk1(16'h0001, 16'h8001, pa, pb, lat);
      chk("post_rst_v1", {pa, pb}, 32'h4001_C001);
      blk12(ca, cb, pa, pb, lat, ok);
      chk("post_rst_rt", {pa, pb}, 32'hA5A5_5A5A);

      // Key write while a block is in flight.
      enc(16'h1357, 16'h2468, ca, cb);
      ca12 = ca; cb12 = cb; v12 = 1'b1;
      tick();
      v12 = 1'b0;
      tick();
      k12_we = 1'b1; k12_addr = 5'd5; k12_data = 16'hBEEF;
      #1;
`ifdef RC5_DEC_KEY_LOCK_EN
      chk("lock_err_pulse", 32'(err12), 32'h1);
`else
      chk("nolock_err", 32'(err12), 32'h0);
`endif
      tick();
      k12_we = 1'b0;
      #1;
      chk("err_clear", 32'(err12), 32'h0);
      lat = 0;
      while (!ov12 && lat < 100) begin tick(); lat++; end
      pa = pa12; pb = pb12;
      or12 = 1'b1;
      tick();
      or12 = 1'b0;
`ifdef RC5_DEC_KEY_LOCK_EN
      chk("lock_pt", {pa, pb}, 32'h1357_2468);
`else
      chk("nolock_corrupt", 32'({pa, pb} != 32'h1357_2468), 32'h1);
`endif
      key12(5, st[5]);
      blk12(ca, cb, pa, pb, lat, ok);
      chk("restored_rt", {pa, pb}, 32'h1357_2468);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
